// File: rtl/slice_decode_sequencer_if.sv
// Slice decode sequencer bus: slice control, VLD handshakes and status.
// Clock and reset stay as plain ports on the sequencer.
interface slice_decode_sequencer_if;
  logic        slice_start;
  logic [31:0] block_num;
  logic        dc_coef_valid;
  logic        ac_pos_valid;
  logic [6:0]  ac_pos_inc;
  logic        slice_bits_empty;
  logic        dc_vld_reset;
  logic        ac_vld_reset;
  logic [31:0] dc_index;
  logic [31:0] ac_position;
  logic        idct_start;
  logic        slice_done;
  logic        busy;
  logic        ac_overrun;
  logic [31:0] cycle_count;

  modport master (
    output slice_start, block_num, dc_coef_valid,
    output ac_pos_valid, ac_pos_inc, slice_bits_empty,
    input  dc_vld_reset, ac_vld_reset, dc_index,
    input  ac_position, idct_start, slice_done,
    input  busy, ac_overrun, cycle_count
  );

  modport slave (
    input  slice_start, block_num, dc_coef_valid,
    input  ac_pos_valid, ac_pos_inc, slice_bits_empty,
    output dc_vld_reset, ac_vld_reset, dc_index,
    output ac_position, idct_start, slice_done,
    output busy, ac_overrun, cycle_count
  );
endinterface

// File: rtl/slice_decode_sequencer.sv
// Decode-side slice sequencer: releases DC then AC VLDs, counts what they
// report, fires the IDCT, waits out its latency and flags slice completion.
module slice_decode_sequencer #(
  parameter int IDCT_TIME = 12
) (
  input logic                     clock,
  input logic                     reset_n,
  slice_decode_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DC,
    S_AC,
    S_IDCT,
    S_DONE
  } state_t;

  localparam logic [31:0] WAIT_INIT = 32'(IDCT_TIME - 1);

  state_t      r_state;
  logic [31:0] r_block_q;
  logic [31:0] r_ac_total;
  logic [31:0] r_wait;
  logic        r_dc_vld_reset;
  logic        r_ac_vld_reset;
  logic [31:0] r_dc_index;
  logic [31:0] r_ac_position;
  logic        r_idct_start;
  logic        r_slice_done;
  logic        r_busy;
  logic        r_ac_overrun;
  logic [31:0] r_cycle_count;

  logic [31:0] w_inc;
  logic [31:0] w_sum;
  logic        w_dc_last;

  assign w_inc = bus.ac_pos_valid ? {25'd0, bus.ac_pos_inc} : 32'd0;
  assign w_sum = r_ac_position + w_inc;
  assign w_dc_last = (r_dc_index == r_block_q - 32'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_block_q      <= '0;
      r_ac_total     <= '0;
      r_wait         <= '0;
      r_dc_vld_reset <= 1'b0;
      r_ac_vld_reset <= 1'b0;
      r_dc_index     <= '0;
      r_ac_position  <= '0;
      r_idct_start   <= 1'b0;
      r_slice_done   <= 1'b0;
      r_busy         <= 1'b0;
      r_ac_overrun   <= 1'b0;
      r_cycle_count  <= '0;
    end else begin
      r_idct_start <= 1'b0;
      r_slice_done <= 1'b0;
      if (r_busy)
        r_cycle_count <= r_cycle_count + 32'd1;
      unique case (r_state)
        S_IDLE: begin
          if (bus.slice_start) begin
            r_block_q     <= bus.block_num;
            r_ac_total    <= 32'd63 * bus.block_num;
            r_dc_index    <= '0;
            r_ac_position <= '0;
            r_ac_overrun  <= 1'b0;
            r_cycle_count <= '0;
            r_busy        <= 1'b1;
            if (bus.block_num != 32'd0) begin
              r_state        <= S_DC;
              r_dc_vld_reset <= 1'b1;
            end else begin
              // Empty slice: skip both VLDs and go straight to the IDCT
              r_state      <= S_IDCT;
              r_idct_start <= 1'b1;
              r_wait       <= WAIT_INIT;
            end
          end
        end
        S_DC: begin
          if (bus.dc_coef_valid) begin
            r_dc_index <= r_dc_index + 32'd1;
            if (w_dc_last) begin
              r_state        <= S_AC;
              r_dc_vld_reset <= 1'b0;
              r_ac_vld_reset <= 1'b1;
            end
          end
        end
        S_AC: begin
          if (bus.ac_pos_valid)
            r_ac_position <= w_sum;
          if (w_sum > r_ac_total)
            r_ac_overrun <= 1'b1;
          // Early bit exhaustion leaves trailing positions as implicit zeros
          if (w_sum >= r_ac_total || bus.slice_bits_empty) begin
            r_state        <= S_IDCT;
            r_ac_vld_reset <= 1'b0;
            r_idct_start   <= 1'b1;
            r_wait         <= WAIT_INIT;
          end
        end
        S_IDCT: begin
          if (r_wait == 32'd0) begin
            r_state      <= S_DONE;
            r_slice_done <= 1'b1;
          end else begin
            r_wait <= r_wait - 32'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.dc_vld_reset = r_dc_vld_reset;
  assign bus.ac_vld_reset = r_ac_vld_reset;
  assign bus.dc_index     = r_dc_index;
  assign bus.ac_position  = r_ac_position;
  assign bus.idct_start   = r_idct_start;
  assign bus.slice_done   = r_slice_done;
  assign bus.busy         = r_busy;
  assign bus.ac_overrun   = r_ac_overrun;
  assign bus.cycle_count  = r_cycle_count;

endmodule
